// File: rtl/rr_mux_reg_if.sv
// Handshake bundle for rr_mux_reg: producer-side valid/data/ready lanes and the consumer port.
// RR_MUX_PKT_LOCK_EN adds the in_last/out_last packet framing signals.
interface rr_mux_reg_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int SEL_W  = $clog2(NUM_CH)
);
   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_ready;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_ch;
   logic                    out_ready;
`ifdef RR_MUX_PKT_LOCK_EN
   logic [NUM_CH-1:0]       in_last;
   logic                    out_last;
`endif

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
`ifdef RR_MUX_PKT_LOCK_EN
      input  in_last,
      output out_last,
`endif
      output in_ready, out_valid, out_data, out_ch
   );

   modport master (
      output mode, sel, in_valid, in_data, out_ready,
`ifdef RR_MUX_PKT_LOCK_EN
      output in_last,
      input  out_last,
`endif
      input  in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/rr_mux_reg.sv
// N-channel valid/ready selector (fixed select or round-robin) feeding one registered output entry.
// Optional macro RR_MUX_PKT_LOCK_EN locks the grant to a channel until its last beat.
module rr_mux_reg #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic        clk,
   input  logic        rst_n,
   rr_mux_reg_if.slave bus
);
   localparam logic [SEL_W:0]   NCH_W   = (SEL_W+1)'(NUM_CH);
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

   logic              can_load_s;
   logic              gnt_vld_s;
   logic [SEL_W-1:0]  gnt_idx_s;
   logic [WIDTH-1:0]  gnt_data_s;
   logic              gnt_last_s;
   logic              xfer_in_s;
   logic              ptr_adv_s;
   logic [NUM_CH-1:0] in_ready_s;
   logic [SEL_W-1:0]  ptr_r;
   logic              out_valid_r;
   logic [WIDTH-1:0]  out_data_r;
   logic [SEL_W-1:0]  out_ch_r;
`ifdef RR_MUX_PKT_LOCK_EN
   logic              lock_r;
   logic [SEL_W-1:0]  lock_ch_r;
   logic              out_last_r;
`endif

   function automatic logic bit_at(input logic [NUM_CH-1:0] vec, input logic [SEL_W-1:0] idx);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit = hit | (vec[i] & (idx == SEL_W'(i)));
      end
      return hit;
   endfunction

   // Arbitration: an open packet overrides, otherwise fixed select or RR search starting at ptr
   always_comb begin
      logic [SEL_W:0] cand_v;
      cand_v    = '0;
      gnt_vld_s = 1'b0;
      gnt_idx_s = '0;
`ifdef RR_MUX_PKT_LOCK_EN
      if (lock_r) begin
         gnt_vld_s = bit_at(bus.in_valid, lock_ch_r);
         gnt_idx_s = lock_ch_r;
      end else
`endif
      if (bus.mode == 1'b0) begin
         if (({1'b0, bus.sel} < NCH_W) && bit_at(bus.in_valid, bus.sel)) begin
            gnt_vld_s = 1'b1;
            gnt_idx_s = bus.sel;
         end else begin
            gnt_vld_s = 1'b0;
         end
      end else begin
         // Walk offsets from farthest to nearest so the nearest valid channel wins
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand_v = {1'b0, ptr_r} + (SEL_W+1)'(k);
            cand_v = (cand_v >= NCH_W) ? (cand_v - NCH_W) : cand_v;
            if (bit_at(bus.in_valid, cand_v[SEL_W-1:0])) begin
               gnt_vld_s = 1'b1;
               gnt_idx_s = cand_v[SEL_W-1:0];
            end else begin
               gnt_vld_s = gnt_vld_s;
            end
         end
      end
   end

   // Granted channel's payload and handshake qualification
   always_comb begin
      gnt_data_s = '0;
      gnt_last_s = 1'b1;
      in_ready_s = '0;
      can_load_s = ~out_valid_r | bus.out_ready;
      xfer_in_s  = gnt_vld_s & can_load_s & rst_n;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt_idx_s == SEL_W'(i)) begin
            gnt_data_s = bus.in_data[i*WIDTH +: WIDTH];
`ifdef RR_MUX_PKT_LOCK_EN
            gnt_last_s = bus.in_last[i];
`endif
         end else begin
            gnt_data_s = gnt_data_s;
         end
         in_ready_s[i] = xfer_in_s & (gnt_idx_s == SEL_W'(i));
      end
      ptr_adv_s = xfer_in_s & bus.mode & gnt_last_s;
   end

   // Output entry: load on transfer in, empty on drain without a replacement, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_ch_r    <= '0;
`ifdef RR_MUX_PKT_LOCK_EN
         out_last_r  <= 1'b0;
`endif
      end else if (xfer_in_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= gnt_data_s;
         out_ch_r    <= gnt_idx_s;
`ifdef RR_MUX_PKT_LOCK_EN
         out_last_r  <= gnt_last_s;
`endif
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Round-robin pointer moves just past the channel that completed a transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (ptr_adv_s) begin
         ptr_r <= (gnt_idx_s == LAST_CH) ? '0 : (gnt_idx_s + SEL_W'(1));
      end else begin
         ptr_r <= ptr_r;
      end
   end

`ifdef RR_MUX_PKT_LOCK_EN
   // Packet lock: held from a non-last beat until the same channel sends its last beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_r    <= 1'b0;
         lock_ch_r <= '0;
      end else if (xfer_in_s) begin
         lock_r    <= ~gnt_last_s;
         lock_ch_r <= gnt_idx_s;
      end else begin
         lock_r    <= lock_r;
      end
   end

   assign bus.out_last  = out_last_r;
`endif

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_ch    = out_ch_r;
endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed and randomized bench for rr_mux_reg against a cycle-level reference model.
module tb_rr_mux_reg;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = $clog2(N);
`ifdef RR_MUX_PKT_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   bit m_valid;
   int m_data;
   int m_ch;
   int m_ptr;
   bit m_lock;
   int m_lch;
   bit m_last;

   logic [N*W-1:0] dpat;
   logic [N*W-1:0] rdat;

   always #5 clk = ~clk;

   rr_mux_reg_if #(.NUM_CH(N), .WIDTH(W)) bus ();
   rr_mux_reg #(.NUM_CH(N), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_data = 0; m_ch = 0; m_ptr = 0;
      m_lock = 1'b0; m_lch = 0; m_last = 1'b0;
   endtask

   function automatic int pick(input bit mode, input int sel, input logic [N-1:0] v);
      if (m_lock) return v[m_lch] ? m_lch : -1;
      if (!mode) return (sel < N && v[sel]) ? sel : -1;
      for (int k = 0; k < N; k++) begin
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "/out_valid"}, 32'(bus.out_valid), 32'(m_valid));
      check({tag, "/out_data"},  32'(bus.out_data),  32'(m_data));
      check({tag, "/out_ch"},    32'(bus.out_ch),    32'(m_ch));
`ifdef RR_MUX_PKT_LOCK_EN
      check({tag, "/out_last"},  32'(bus.out_last),  32'(m_last));
`endif
   endtask

   // One clock: check registered state, drive inputs, check in_ready, advance model
   task automatic cycle(input bit mode, input int sel, input logic [N-1:0] v,
                        input logic [N*W-1:0] d, input bit ordy, input logic [N-1:0] last,
                        input string tag);
      int g;
      bit load;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      check_outputs(tag);
      bus.mode = mode; bus.sel = SW'(sel); bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy;
`ifdef RR_MUX_PKT_LOCK_EN
      bus.in_last = last;
`endif
      #1;
      g = pick(mode, sel, v);
      load = (g >= 0) && (!m_valid || ordy);
      exp_rdy = '0;
      if (load) exp_rdy[g] = 1'b1;
      check({tag, "/in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
      if (load) begin
         m_valid = 1'b1;
         m_data  = int'(d[g*W +: W]);
         m_ch    = g;
         m_last  = LOCK ? last[g] : 1'b0;
         if (LOCK) begin
            m_lock = !last[g];
            m_lch  = g;
         end
         if (mode && (!LOCK || last[g])) m_ptr = (g + 1) % N;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      check_outputs({tag, "/pre"});
      rst_n = 1'b0;
      #1;
      check({tag, "/async_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "/rst_ready"},   32'(bus.in_ready),  32'd0);
      model_reset();
      bus.in_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
`ifdef RR_MUX_PKT_LOCK_EN
      bus.in_last = '0;
`endif
      model_reset();
      dpat = {8'h33, 8'h22, 8'h11, 8'h00};
      #12;
      check_outputs("reset");
      bus.in_valid = 4'hF;
      #1;
      check("reset/in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int s = 0; s < N; s++) cycle(1'b0, s, 4'hF, dpat, 1'b1, '1, "fixed");
      for (int i = 0; i < 8; i++) cycle(1'b1, 0, 4'hF, dpat, 1'b1, '1, "rr_all");
      for (int i = 0; i < 4; i++) cycle(1'b1, 0, 4'b1010, dpat, 1'b1, '1, "rr_1010");

      cycle(1'b1, 0, 4'hF, dpat, 1'b1, '1, "bp_load");
      for (int i = 0; i < 3; i++) cycle(1'b1, 0, 4'hF, dpat, 1'b0, '1, "bp_hold");
      cycle(1'b1, 0, 4'hF, dpat, 1'b1, '1, "bp_release");

      cycle(1'b0, 3, 4'b0111, dpat, 1'b1, '1, "sel3_idle");
      cycle(1'b0, 3, 4'b0111, dpat, 1'b1, '1, "sel3_idle2");
      cycle(1'b1, 0, 4'b0110, dpat, 1'b0, '1, "pre_rst_load");
      cycle(1'b1, 0, 4'b0110, dpat, 1'b0, '1, "pre_rst_hold");
      do_reset("mid_rst");
      cycle(1'b1, 0, 4'hF, dpat, 1'b1, '1, "post_rst");
      cycle(1'b1, 0, 4'h0, dpat, 1'b1, '1, "post_rst_drain");

`ifdef RR_MUX_PKT_LOCK_EN
      do_reset("lock_rst");
      cycle(1'b1, 0, 4'b0110, dpat, 1'b1, 4'b0100, "pkt_b1");
      cycle(1'b1, 0, 4'b0100, dpat, 1'b1, 4'b0100, "pkt_idle");
      cycle(1'b1, 0, 4'b0110, dpat, 1'b1, 4'b0100, "pkt_b2");
      cycle(1'b1, 0, 4'b0110, dpat, 1'b1, 4'b0110, "pkt_b3");
      cycle(1'b1, 0, 4'b0110, dpat, 1'b1, 4'b0110, "pkt_next");
      cycle(1'b1, 0, 4'b0000, dpat, 1'b1, 4'b0000, "pkt_drain");
`endif

      for (int i = 0; i < 400; i++) begin
         if (i % 150 == 149) do_reset("rand_rst");
         rdat = N*W'($urandom);
         cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)), N'($urandom), rdat,
               ($urandom_range(0, 3) != 0), N'($urandom), "rand");
      end

      @(negedge clk);
      check_outputs("final");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
